// File: rtl/fpu_fp16_to_int.sv
// Iterative FP16 to signed-integer converter.
// Serial right-shift alignment, round-to-nearest-even and saturation.
package fpu_fp16_to_int_pkg;
  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] frac;
  } fp16_t;
endpackage

module fpu_fp16_to_int #(
  parameter int INTW = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            inValid,
  output logic            inReady,
  input  logic [15:0]     fpuIn,
  output logic            outValid,
  input  logic            outReady,
  output logic [INTW-1:0] intOut,
  output logic [2:0]      opStatusFlags
);
  import fpu_fp16_to_int_pkg::*;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ROUND,
    OUT
  } state_t;

  localparam logic signed [7:0] EMAX = 8'(INTW - 1);
  localparam logic [INTW:0] LIMN = {2'b01, {(INTW-1){1'b0}}};
  localparam logic [INTW:0] LIMP = LIMN - 1'b1;
  localparam logic [INTW-1:0] MAXP = {1'b0, {(INTW-1){1'b1}}};
  localparam logic [INTW-1:0] MINN = {1'b1, {(INTW-1){1'b0}}};

  state_t state_q, state_d;

  fp16_t op;
  logic [4:0] exp_eff;
  logic signed [7:0] e_val;
  logic signed [7:0] sh;
  logic [10:0] sig;
  logic [4:0] lsh;
  logic [INTW:0] sig_shl;
  logic is_nan;
  logic special;
  logic to_shift;

  logic sign_q, sat_q, sat_neg_q;
  logic guard_q, sticky_q;
  logic [INTW:0] mag_q;
  logic [3:0] cnt_q;
  logic [INTW-1:0] res_q;
  logic [2:0] flg_q;

  logic inc;
  logic [INTW:0] rnd;
  logic [INTW-1:0] rnd_lo;
  logic ovf;
  logic sat_neg;

  assign op = fpuIn;
  assign exp_eff = (op.exp == 5'd0) ? 5'd1 : op.exp;
  assign e_val = $signed({3'b000, exp_eff}) - 8'sd15;
  assign sh = 8'sd10 - e_val;
  assign sig = {op.exp != 5'd0, op.frac};
  assign lsh = 5'(-sh);
  assign sig_shl = {{(INTW-10){1'b0}}, sig} << lsh;
  assign is_nan = (op.exp == 5'h1f) && (op.frac != 10'd0);
  assign special = (op.exp == 5'h1f) || (e_val > EMAX);
  assign to_shift = !special && (sh > 8'sd0) && (sh < 8'sd12);

  // Nearest-even: round up past the half, or on a tie with odd LSB
  assign inc = guard_q & (sticky_q | mag_q[0]);
  assign rnd = mag_q + {{INTW{1'b0}}, inc};
  assign rnd_lo = rnd[INTW-1:0];
  assign ovf = sign_q ? (rnd > LIMN) : (rnd > LIMP);
  assign sat_neg = sat_q ? sat_neg_q : sign_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    inReady  = 1'b0;
    outValid = 1'b0;
    unique case (state_q)
      IDLE: begin
        inReady = 1'b1;
        if (inValid) begin
          state_d = to_shift ? SHIFT : ROUND;
        end
      end
      SHIFT: begin
        if (cnt_q == 4'd1) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        state_d = OUT;
      end
      OUT: begin
        outValid = 1'b1;
        if (outReady) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sign_q    <= 1'b0;
      sat_q     <= 1'b0;
      sat_neg_q <= 1'b0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      mag_q     <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      flg_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (inValid) begin
            sign_q    <= op.sign;
            sat_q     <= special;
            sat_neg_q <= op.sign & ~is_nan;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            mag_q     <= '0;
            if (!special) begin
              if (sh <= 8'sd0) begin
                mag_q <= sig_shl;
              end else if (sh < 8'sd12) begin
                mag_q <= {{(INTW-10){1'b0}}, sig};
                cnt_q <= sh[3:0];
              end else begin
                sticky_q <= |sig;
              end
            end
          end
        end
        SHIFT: begin
          sticky_q <= sticky_q | guard_q;
          guard_q  <= mag_q[0];
          mag_q    <= mag_q >> 1;
          cnt_q    <= cnt_q - 4'd1;
        end
        ROUND: begin
          if (sat_q || ovf) begin
            res_q <= sat_neg ? MINN : MAXP;
            flg_q <= 3'b100;
          end else begin
            res_q <= sign_q ? -rnd_lo : rnd_lo;
            flg_q <= {2'b00, guard_q | sticky_q};
          end
        end
        OUT: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign intOut = res_q;
  assign opStatusFlags = flg_q;

endmodule

// File: tb/tb_fpu_fp16_to_int.sv
// Directed and random checks of fpu_fp16_to_int (INTW=16).
// Scoreboard queue of expected results, compared when outValid rises.
module tb_fpu_fp16_to_int;

  logic        clock;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [15:0] fpuIn;
  logic        outValid;
  logic        outReady;
  logic [15:0] intOut;
  logic [2:0]  opStatusFlags;

  typedef struct {
    logic [15:0] a;
    logic [15:0] r;
    logic [2:0]  f;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

  fpu_fp16_to_int #(.INTW(16)) dut (
    .clock(clock),
    .reset(reset),
    .inValid(inValid),
    .inReady(inReady),
    .fpuIn(fpuIn),
    .outValid(outValid),
    .outReady(outReady),
    .intOut(intOut),
    .opStatusFlags(opStatusFlags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer division with remainder-based rounding
  function automatic void model(input logic [15:0] a,
                                output logic [15:0] r,
                                output logic [2:0] f,
                                output int lat);
    int e, sh;
    longint sig, q, rem, half, lim;
    bit s, nx, neg_sat;
    s = a[15];
    e = ((a[14:10] == 5'd0) ? 1 : int'(a[14:10])) - 15;
    sig = longint'({a[14:10] != 5'd0, a[9:0]});
    sh = 10 - e;
    lat = 2;
    nx = 1'b0;
    neg_sat = s && !(a[14:10] == 5'h1f && a[9:0] != 10'd0);
    if (a[14:10] == 5'h1f || e > 15) begin
      r = neg_sat ? 16'h8000 : 16'h7fff;
      f = 3'b100;
      return;
    end
    if (sh <= 0) begin
      q = sig << (-sh);
    end else begin
      if (sh <= 11) lat = sh + 2;
      q = sig >> sh;
      rem = sig - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      nx = (rem != 0);
    end
    lim = s ? 32768 : 32767;
    if (q > lim) begin
      r = s ? 16'h8000 : 16'h7fff;
      f = 3'b100;
    end else begin
      r = s ? 16'(-q) : 16'(q);
      f = {2'b00, nx};
    end
  endfunction

  task automatic run(input logic [15:0] a, input logic [15:0] er,
                     input logic [2:0] ef, input int el, input int hold);
    exp_t e;
    int lat;
    logic [15:0] held_r;
    logic [2:0] held_f;
    sb.push_back('{a, er, ef, el});
    @(negedge clock);
    check($sformatf("inReady_idle[%h]", a), inReady, 1);
    outReady = (hold == 0);
    fpuIn = a;
    inValid = 1'b1;
    @(posedge clock);
    lat = 1;
    @(negedge clock);
    inValid = 1'b0;
    fpuIn = 16'h0;
    while (!outValid && lat < 100) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    check($sformatf("outValid_seen[%h]", a), outValid, 1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check($sformatf("intOut[%h]", e.a), intOut, e.r);
      check($sformatf("flags[%h]", e.a), opStatusFlags, e.f);
      check($sformatf("latency[%h]", e.a), lat, e.lat);
    end
    held_r = intOut;
    held_f = opStatusFlags;
    for (int i = 0; i < hold; i++) begin
      inValid = 1'b1;
      fpuIn = 16'h4000;
      @(posedge clock);
      @(negedge clock);
      check("hold_outValid", outValid, 1);
      check("hold_inReady", inReady, 0);
      check("hold_intOut", intOut, er);
      check("hold_flags", opStatusFlags, ef);
    end
    outReady = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check($sformatf("drain_outValid[%h]", a), outValid, 0);
    check($sformatf("drain_inReady[%h]", a), inReady, 1);
    check($sformatf("drain_keep[%h]", a), {intOut, opStatusFlags},
          {held_r, held_f});
    inValid = 1'b0;
    fpuIn = 16'h0;
  endtask

  initial begin
    logic [15:0] ra, rr;
    logic [2:0] rf;
    int rl;
    int seen;
    reset = 1'b1;
    inValid = 1'b0;
    fpuIn = 16'h0;
    outReady = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_inReady", inReady, 1);
    check("rst_outValid", outValid, 0);
    check("rst_intOut", intOut, 0);
    check("rst_flags", opStatusFlags, 0);
    reset = 1'b0;

    run(16'h3c00, 16'h0001, 3'b000, 12, 0);
    run(16'h3e00, 16'h0002, 3'b001, 12, 0);
    run(16'h4100, 16'h0002, 3'b001, 11, 0);
    run(16'h4300, 16'h0004, 3'b001, 11, 0);
    run(16'hc500, 16'hfffb, 3'b000, 10, 0);
    run(16'h8000, 16'h0000, 3'b000, 2, 0);
    run(16'h0001, 16'h0000, 3'b001, 2, 0);
    run(16'h3800, 16'h0000, 3'b001, 13, 0);
    run(16'h7800, 16'h7fff, 3'b100, 2, 0);
    run(16'hf800, 16'h8000, 3'b000, 2, 0);
    run(16'h7c00, 16'h7fff, 3'b100, 2, 0);
    run(16'hfc00, 16'h8000, 3'b100, 2, 0);
    run(16'h7e00, 16'h7fff, 3'b100, 2, 0);
    run(16'hfe00, 16'h7fff, 3'b100, 2, 0);
    run(16'h77ff, 16'h7ff0, 3'b000, 2, 0);
    run(16'hf7ff, 16'h8010, 3'b000, 2, 0);
    run(16'hc300, 16'hfffc, 3'b001, 11, 0);

    run(16'h4500, 16'h0005, 3'b000, 10, 5);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      model(ra, rr, rf, rl);
      run(ra, rr, rf, rl, 0);
    end

    // Reset in the middle of a SHIFT sequence
    @(negedge clock);
    fpuIn = 16'h3c00;
    inValid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    inValid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("midrst_outValid", outValid, 0);
    check("midrst_inReady", inReady, 1);
    check("midrst_intOut", intOut, 0);
    check("midrst_flags", opStatusFlags, 0);
    reset = 1'b0;
    seen = 0;
    repeat (15) begin
      @(posedge clock);
      @(negedge clock);
      if (outValid) seen++;
    end
    check("midrst_no_stale", seen, 0);

    run(16'hc100, 16'hfffe, 3'b001, 11, 0);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
